// File: rtl/seq_multiplier_n.sv
// Sequential shift-add multiplier: one multiplier bit per clock, WIDTH-cycle fixed latency.
// Define SEQ_MULT_SIGNED_EN to treat io_A/io_B as two's complement (sign-magnitude internally).
module seq_multiplier_n #(
   parameter int WIDTH = 4
) (
   input  logic               io_clk,
   input  logic               io_rst,
   input  logic               io_start,
   input  logic [WIDTH-1:0]   io_A,
   input  logic [WIDTH-1:0]   io_B,
   output logic               io_busy,
   output logic               io_done,
   output logic [2*WIDTH-1:0] io_Product
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [PW-1:0]    r_mcand;
   logic [PW-1:0]    r_acc;
   logic [PW-1:0]    r_prod;
   logic [PW-1:0]    w_acc_sum;
   logic [PW-1:0]    w_result;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [CW-1:0]    r_cnt;
   logic             w_accept;
   logic             w_last;

   // Valid/ready: a request is taken on any edge where io_start=1 and the block is not BUSY.
   assign w_accept  = io_start && (r_state != S_BUSY);
   assign w_last    = (r_cnt == CW'(WIDTH - 1));
   assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

`ifdef SEQ_MULT_SIGNED_EN
   logic r_sign;

   // Negating the most-negative value yields the same bit pattern, which is its correct magnitude.
   assign w_a_mag  = io_A[WIDTH-1] ? -io_A : io_A;
   assign w_b_mag  = io_B[WIDTH-1] ? -io_B : io_B;
   assign w_result = r_sign ? -w_acc_sum : w_acc_sum;

   always_ff @(posedge io_clk or posedge io_rst) begin
      if (io_rst) begin
         r_sign <= 1'b0;
      end else if (w_accept) begin
         r_sign <= io_A[WIDTH-1] ^ io_B[WIDTH-1];
      end
   end
`else
   assign w_a_mag  = io_A;
   assign w_b_mag  = io_B;
   assign w_result = w_acc_sum;
`endif

   always_ff @(posedge io_clk or posedge io_rst) begin
      if (io_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      io_busy = 1'b0;
      io_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (io_start) w_next = S_BUSY;
         end
         S_BUSY: begin
            io_busy = 1'b1;
            if (w_last) w_next = S_DONE;
         end
         S_DONE: begin
            io_done = 1'b1;
            w_next  = io_start ? S_BUSY : S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // The final iteration's sum goes straight to the product register, so no partial sum is ever visible.
   always_ff @(posedge io_clk or posedge io_rst) begin
      if (io_rst) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_prod   <= '0;
      end else if (w_accept) begin
         r_mcand  <= PW'(w_a_mag);
         r_mplier <= w_b_mag;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else if (r_state == S_BUSY) begin
         r_acc    <= w_acc_sum;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + CW'(1);
         if (w_last) r_prod <= w_result;
      end
   end

   assign io_Product = r_prod;

endmodule

// File: tb/tb_seq_multiplier_n.sv
// Bench for seq_multiplier_n: WIDTH=4 instance (vector table, corner sequences, random ops)
// plus a WIDTH=8 instance. Expected products come from literal tables and a multiply model.
module tb_seq_multiplier_n;

   logic       clk;
   logic       rst;
   logic       st4;
   logic [3:0] a4, b4;
   logic       busy4, done4;
   logic [7:0] prod4;
   logic       st8;
   logic [7:0] a8, b8;
   logic       busy8, done8;
   logic [15:0] prod8;

   logic [7:0]  exp_q[$];
   logic [15:0] exp8_q[$];
   logic [7:0]  last4;
   logic [15:0] last8;
   int total;
   int bad;

   seq_multiplier_n #(.WIDTH(4)) u_dut4 (
      .io_clk(clk), .io_rst(rst), .io_start(st4), .io_A(a4), .io_B(b4),
      .io_busy(busy4), .io_done(done4), .io_Product(prod4)
   );

   seq_multiplier_n #(.WIDTH(8)) u_dut8 (
      .io_clk(clk), .io_rst(rst), .io_start(st8), .io_A(a8), .io_B(b8),
      .io_busy(busy8), .io_done(done8), .io_Product(prod8)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] e;
   } vec_t;

   vec_t vecs[10];

`ifdef SEQ_MULT_SIGNED_EN
   localparam logic [7:0]  EXP_12_11 = 8'h14;
   localparam logic [15:0] EXP8_FF   = 16'h0001;
   localparam logic [15:0] EXP8_C864 = 16'hEA20;
`else
   localparam logic [7:0]  EXP_12_11 = 8'h84;
   localparam logic [15:0] EXP8_FF   = 16'hFE01;
   localparam logic [15:0] EXP8_C864 = 16'h4E20;
`endif

   function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b);
`ifdef SEQ_MULT_SIGNED_EN
      logic signed [7:0] r;
      r = $signed(a) * $signed(b);
      return r;
`else
      logic [7:0] r;
      r = a * b;
      return r;
`endif
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // driver: one full WIDTH=4 transaction with per-cycle checks
   task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] e);
      int n;
      logic [7:0] got;
      @(negedge clk);
      a4 = a; b4 = b; st4 = 1'b1;
      @(posedge clk);
      exp_q.push_back(e);
      @(negedge clk);
      st4 = 1'b0;
      n = 0;
      while (!done4 && n < 20) begin
         chk("busy4", 16'(busy4), 16'd1);
         chk("hold4", 16'(prod4), 16'(last4));
         a4 = 4'($urandom_range(0, 15));
         b4 = 4'($urandom_range(0, 15));
         n++;
         @(negedge clk);
      end
      chk("latency4", 16'(n), 16'd4);
      chk("done4", 16'(done4), 16'd1);
      chk("busy_in_done4", 16'(busy4), 16'd0);
      got = exp_q.pop_front();
      chk("product4", 16'(prod4), 16'(got));
      last4 = got;
   endtask

   task automatic wait_done4(output int n);
      n = 0;
      while (!done4 && n < 20) begin
         chk("busy4_seq", 16'(busy4), 16'd1);
         n++;
         @(negedge clk);
      end
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e);
      int n;
      logic [15:0] got;
      @(negedge clk);
      a8 = a; b8 = b; st8 = 1'b1;
      @(posedge clk);
      exp8_q.push_back(e);
      @(negedge clk);
      st8 = 1'b0;
      n = 0;
      while (!done8 && n < 40) begin
         chk("busy8", 16'(busy8), 16'd1);
         chk("hold8", prod8, last8);
         n++;
         @(negedge clk);
      end
      chk("latency8", 16'(n), 16'd8);
      chk("done8", 16'(done8), 16'd1);
      got = exp8_q.pop_front();
      chk("product8", prod8, got);
      last8 = got;
   endtask

   initial begin
      int n;
      logic [7:0] got;
      logic [3:0] ra, rb;
      total = 0; bad = 0;
      last4 = '0; last8 = '0;
      st4 = 0; a4 = '0; b4 = '0;
      st8 = 0; a8 = '0; b8 = '0;

`ifdef SEQ_MULT_SIGNED_EN
      vecs = '{'{4'd15, 4'd15, 8'h01}, '{4'd0, 4'd9, 8'h00}, '{4'd9, 4'd1, 8'hF9},
               '{4'd3, 4'd5, 8'h0F},   '{4'd8, 4'd7, 8'hC8}, '{4'd8, 4'd8, 8'h40},
               '{4'd15, 4'd1, 8'hFF},  '{4'd12, 4'd11, 8'h14}, '{4'd1, 4'd15, 8'hFF},
               '{4'd10, 4'd6, 8'hDC}};
`else
      vecs = '{'{4'd15, 4'd15, 8'hE1}, '{4'd0, 4'd9, 8'h00}, '{4'd9, 4'd1, 8'h09},
               '{4'd3, 4'd5, 8'h0F},   '{4'd8, 4'd7, 8'h38}, '{4'd8, 4'd8, 8'h40},
               '{4'd15, 4'd1, 8'h0F},  '{4'd12, 4'd11, 8'h84}, '{4'd1, 4'd15, 8'h0F},
               '{4'd10, 4'd6, 8'h3C}};
`endif

      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy4", 16'(busy4), 16'd0);
      chk("rst_done4", 16'(done4), 16'd0);
      chk("rst_prod4", 16'(prod4), 16'd0);
      chk("rst_prod8", prod8, 16'd0);
      rst = 1'b0;

      foreach (vecs[i]) op4(vecs[i].a, vecs[i].b, vecs[i].e);

      // request during BUSY is ignored
      @(negedge clk);
      a4 = 4'd3; b4 = 4'd5; st4 = 1'b1;
      @(posedge clk);
      exp_q.push_back(8'h0F);
      @(negedge clk);
      st4 = 1'b0; a4 = 4'd15; b4 = 4'd15;
      @(negedge clk);
      st4 = 1'b1;
      @(negedge clk);
      st4 = 1'b0;
      wait_done4(n);
      chk("ign_latency", 16'(n + 2), 16'd4);
      chk("ign_done", 16'(done4), 16'd1);
      got = exp_q.pop_front();
      chk("ign_product", 16'(prod4), 16'(got));
      last4 = got;
      repeat (6) begin
         @(negedge clk);
         chk("ign_no_done", 16'(done4), 16'd0);
         chk("ign_idle", 16'(busy4), 16'd0);
      end

      // back-to-back through the DONE cycle
      @(negedge clk);
      a4 = 4'd5; b4 = 4'd3; st4 = 1'b1;
      @(posedge clk);
      exp_q.push_back(8'h0F);
      @(negedge clk);
      a4 = 4'd7; b4 = 4'd6;
      wait_done4(n);
      chk("b2b_lat1", 16'(n), 16'd4);
      chk("b2b_done1", 16'(done4), 16'd1);
      chk("b2b_busy_low", 16'(busy4), 16'd0);
      got = exp_q.pop_front();
      chk("b2b_prod1", 16'(prod4), 16'(got));
      @(posedge clk);
      exp_q.push_back(8'h2A);
      @(negedge clk);
      st4 = 1'b0;
      chk("b2b_rebusy", 16'(busy4), 16'd1);
      chk("b2b_hold", 16'(prod4), 16'h0F);
      wait_done4(n);
      chk("b2b_lat2", 16'(n), 16'd4);
      chk("b2b_done2", 16'(done4), 16'd1);
      got = exp_q.pop_front();
      chk("b2b_prod2", 16'(prod4), 16'(got));
      last4 = got;

      // reset in the middle of an operation
      @(negedge clk);
      a4 = 4'd12; b4 = 4'd11; st4 = 1'b1;
      @(negedge clk);
      st4 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 16'(busy4), 16'd0);
      chk("mid_rst_prod", 16'(prod4), 16'd0);
      chk("mid_rst_done", 16'(done4), 16'd0);
      @(negedge clk);
      rst = 1'b0;
      last4 = '0;
      repeat (8) begin
         @(negedge clk);
         chk("mid_rst_no_done", 16'(done4), 16'd0);
      end
      op4(4'd12, 4'd11, EXP_12_11);

      // random operands against the multiply model
      repeat (8) begin
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         op4(ra, rb, ref4(ra, rb));
      end

      op8(8'd255, 8'd255, EXP8_FF);
      op8(8'd200, 8'd100, EXP8_C864);

      chk("queue4_empty", 16'(exp_q.size()), 16'd0);
      chk("queue8_empty", 16'(exp8_q.size()), 16'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, wanted completion");
      $fatal(1);
   end

endmodule
